// File: rtl/lava_alu.sv
// 8-bit, 16-operation ALU with a single registered result stage.
// The opcode and operands are decoded combinationally and captured on every rising clk edge.
module lava_alu #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   Inst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] BusWires,
    output logic [WIDTH-1:0] DelayedResult
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(2);
    localparam logic [OPW-1:0] OP_OR    = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT   = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL   = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR   = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(8);
    localparam logic [OPW-1:0] OP_INC   = OPW'(9);
    localparam logic [OPW-1:0] OP_DEC   = OPW'(10);
    localparam logic [OPW-1:0] OP_PASSA = OPW'(11);
    localparam logic [OPW-1:0] OP_PASSB = OPW'(12);
    localparam logic [OPW-1:0] OP_ROL   = OPW'(13);
    localparam logic [OPW-1:0] OP_MAX   = OPW'(14);
    localparam logic [OPW-1:0] OP_CLR   = OPW'(15);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [2:0]       w_shamt;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_result;

    assign w_shamt = BusWires[2:0];
    assign w_mul   = A * BusWires;
    // A zero amount makes the right-shift term vanish, so ROL by 0 returns A.
    assign w_rol   = (A << w_shamt) | (A >> (WIDTH - int'(w_shamt)));

    always_comb begin
        w_result = '0;
        case (Inst)
            OP_ADD:   w_result = A + BusWires;
            OP_SUB:   w_result = A - BusWires;
            OP_AND:   w_result = A & BusWires;
            OP_OR:    w_result = A | BusWires;
            OP_XOR:   w_result = A ^ BusWires;
            OP_NOT:   w_result = ~A;
            OP_SHL:   w_result = A << w_shamt;
            OP_SHR:   w_result = A >> w_shamt;
            OP_MUL:   w_result = w_mul;
            OP_INC:   w_result = A + ONE;
            OP_DEC:   w_result = A - ONE;
            OP_PASSA: w_result = A;
            OP_PASSB: w_result = BusWires;
            OP_ROL:   w_result = w_rol;
            OP_MAX:   w_result = (A > BusWires) ? A : BusWires;
            OP_CLR:   w_result = '0;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else begin
            r_result <= w_result;
        end
    end

    assign DelayedResult = r_result;

endmodule

// File: tb/tb_lava_alu.sv
// Directed and swept checks of lava_alu: reset, wrap arithmetic, logic/shift ops,
// back-to-back issue, asynchronous mid-stream reset and a 16-opcode reference sweep.
module tb_lava_alu;

    logic       clk;
    logic       rst;
    logic [3:0] Inst;
    logic [7:0] A;
    logic [7:0] BusWires;
    logic [7:0] DelayedResult;

    int nChecks = 0;
    int nFail   = 0;

    lava_alu #(.WIDTH(8), .OPW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .Inst          (Inst),
        .A             (A),
        .BusWires      (BusWires),
        .DelayedResult (DelayedResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        Inst     = op;
        A        = a;
        BusWires = b;
    endtask

    // Independent reference: shifts and rotates built bit by bit, product taken at full width.
    function automatic logic [7:0] refModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        logic [7:0]  r;
        int          amt;
        amt = int'(b[2:0]);
        r   = a;
        case (op)
            4'd0:  return 8'((16'(a) + 16'(b)) % 256);
            4'd1:  return 8'((16'(a) + 16'd256 - 16'(b)) % 256);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return 8'hFF - a;
            4'd6: begin
                for (int k = 0; k < amt; k++) r = {r[6:0], 1'b0};
                return r;
            end
            4'd7: begin
                for (int k = 0; k < amt; k++) r = {1'b0, r[7:1]};
                return r;
            end
            4'd8: begin
                prod = 16'(a) * 16'(b);
                return prod[7:0];
            end
            4'd9:  return (a == 8'hFF) ? 8'h00 : a + 8'd1;
            4'd10: return (a == 8'h00) ? 8'hFF : a - 8'd1;
            4'd11: return a;
            4'd12: return b;
            4'd13: begin
                for (int k = 0; k < amt; k++) r = {r[6:0], r[7]};
                return r;
            end
            4'd14: return (a >= b) ? a : b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        applyStimulus(4'd0, 8'h00, 8'h00);
        #1;
        nChecks++;
        if (DelayedResult !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL reset_initial: got %h expected 00", DelayedResult);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(i + 11), 8'(8'hA5 + i), 8'(8'h3C ^ i));
            @(posedge clk);
            #1;
            nChecks++;
            if (DelayedResult !== 8'h00) begin
                nFail++;
                $display("[TB] FAIL reset_held[%0d]: got %h expected 00", i, DelayedResult);
            end
        end
        rst = 1'b1;
        applyStimulus(4'd0, 8'h03, 8'h04);
        #2;
        nChecks++;
        if (DelayedResult !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL reset_release_early: got %h expected 00", DelayedResult);
        end
        @(posedge clk);
        #1;
        nChecks++;
        if (DelayedResult !== 8'h07) begin
            nFail++;
            $display("[TB] FAIL reset_first_capture: got %h expected 07", DelayedResult);
        end
    endtask

    task automatic test_arith;
        logic [3:0] ops  [6];
        logic [7:0] as   [6];
        logic [7:0] bs   [6];
        logic [7:0] exps [6];
        ops  = '{4'd0,  4'd1,  4'd8,  4'd8,  4'd9,  4'd10};
        as   = '{8'hFF, 8'h00, 8'h10, 8'h0F, 8'hFF, 8'h00};
        bs   = '{8'h01, 8'h01, 8'h10, 8'h03, 8'h00, 8'h00};
        exps = '{8'h00, 8'hFF, 8'h00, 8'h2D, 8'h00, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            @(posedge clk);
            #1;
            nChecks++;
            if (DelayedResult !== exps[i]) begin
                nFail++;
                $display("[TB] FAIL arith[%0d] op %0d: got %h expected %h", i, ops[i], DelayedResult, exps[i]);
            end
        end
    endtask

    task automatic test_logic;
        logic [3:0] ops  [9];
        logic [7:0] as   [9];
        logic [7:0] bs   [9];
        logic [7:0] exps [9];
        ops  = '{4'd2,  4'd4,  4'd5,  4'd6,  4'd7,  4'd13, 4'd11, 4'd12, 4'd15};
        as   = '{8'hF0, 8'hF0, 8'h5A, 8'h81, 8'h81, 8'h81, 8'h3C, 8'h3C, 8'h77};
        bs   = '{8'h3C, 8'h3C, 8'h00, 8'h01, 8'h09, 8'h01, 8'h99, 8'h99, 8'h88};
        exps = '{8'h30, 8'hCC, 8'hA5, 8'h02, 8'h40, 8'h03, 8'h3C, 8'h99, 8'h00};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            @(posedge clk);
            #1;
            nChecks++;
            if (DelayedResult !== exps[i]) begin
                nFail++;
                $display("[TB] FAIL logic[%0d] op %0d: got %h expected %h", i, ops[i], DelayedResult, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] ops  [4];
        logic [7:0] as   [4];
        logic [7:0] bs   [4];
        logic [7:0] exps [4];
        ops  = '{4'd0,  4'd1,  4'd14, 4'd15};
        as   = '{8'h01, 8'h05, 8'h7F, 8'h12};
        bs   = '{8'h01, 8'h02, 8'h80, 8'h34};
        exps = '{8'h02, 8'h03, 8'h80, 8'h00};
        applyStimulus(ops[0], as[0], bs[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            nChecks++;
            if (DelayedResult !== exps[i]) begin
                nFail++;
                $display("[TB] FAIL b2b_edge[%0d]: got %h expected %h", i, DelayedResult, exps[i]);
            end
            if (i < 3) applyStimulus(ops[i + 1], as[i + 1], bs[i + 1]);
            #6;
            nChecks++;
            if (DelayedResult !== exps[i]) begin
                nFail++;
                $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", i, DelayedResult, exps[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        applyStimulus(4'd11, 8'hAA, 8'h00);
        @(posedge clk);
        #1;
        nChecks++;
        if (DelayedResult !== 8'hAA) begin
            nFail++;
            $display("[TB] FAIL async_preload: got %h expected aa", DelayedResult);
        end
        applyStimulus(4'd12, 8'h00, 8'hEE);
        #1;
        rst = 1'b0;
        #1;
        nChecks++;
        if (DelayedResult !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL async_clear: got %h expected 00", DelayedResult);
        end
        #1;
        rst = 1'b1;
        applyStimulus(4'd12, 8'h00, 8'h55);
        #1;
        nChecks++;
        if (DelayedResult !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL async_after_release: got %h expected 00", DelayedResult);
        end
        @(posedge clk);
        #1;
        nChecks++;
        if (DelayedResult !== 8'h55) begin
            nFail++;
            $display("[TB] FAIL async_resume: got %h expected 55", DelayedResult);
        end
    endtask

    task automatic test_sweep;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expected;
        for (int i = 0; i < 1040; i++) begin
            op = 4'(i % 16);
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            applyStimulus(op, a, b);
            expected = refModel(op, a, b);
            @(posedge clk);
            #1;
            nChecks++;
            if (DelayedResult !== expected) begin
                nFail++;
                $display("[TB] FAIL sweep[%0d] op %0d a %h b %h: got %h expected %h",
                         i, op, a, b, DelayedResult, expected);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'd0, 8'h00, 8'h00);
        test_reset;
        test_arith;
        test_logic;
        test_back_to_back;
        test_async_reset;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
